// File: rtl/clk_div_ctrl.sv
// Control FSM that safely retunes an external clock divider: drain, settle, load, resume.
// Optional DRAIN watchdog enabled by defining CLK_DIV_CTRL_DRAIN_TIMEOUT_EN.
module clk_div_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [5:0]  DEFAULT_RATIO = 6'd1,
   parameter int unsigned DRAIN_TIMEOUT = 128
) (
   input  logic       reference_clk,
   input  logic       reset,
   input  logic       run,
   input  logic       req_valid,
   input  logic [5:0] req_ratio,
   output logic       req_ready,
   input  logic       div_output_clk,
   output logic       clk_divider_enable,
   output logic [5:0] division_ratio,
   output logic       done,
   output logic       err_ratio,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      S_OFF, S_RUN, S_DRAIN, S_SETTLE, S_LOAD, S_RESUME
   } state_e;

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || DRAIN_TIMEOUT < 1) begin : g_param_check
      $error("clk_div_ctrl: SETTLE_CYCLES must be 1..15 and DRAIN_TIMEOUT >= 1");
   end

   state_e     state_q, state_d;
   logic [3:0] settle_cnt_q, settle_cnt_d;
   logic       pend_valid_q, pend_valid_d;
   logic [5:0] pend_ratio_q, pend_ratio_d;
   logic [5:0] ratio_q, ratio_d;
   logic       en_q, en_d;
   logic       ready_q, ready_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic accept, accept_legal, accept_zero;
   logic drain_to, drain_exit;

   assign accept       = req_valid && ready_q;
   assign accept_zero  = accept && (req_ratio == '0);
   assign accept_legal = accept && (req_ratio != '0);

`ifdef CLK_DIV_CTRL_DRAIN_TIMEOUT_EN
   localparam int unsigned DW = $clog2(DRAIN_TIMEOUT + 1);
   logic [DW-1:0] drain_cnt_q, drain_cnt_d;
   logic          timeout_q;

   assign drain_to = (state_q == S_DRAIN) && div_output_clk &&
                     (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1));

   always_comb begin
      drain_cnt_d = '0;
      if (state_q == S_DRAIN) drain_cnt_d = drain_cnt_q + 1'b1;
   end

   always_ff @(posedge reference_clk or posedge reset) begin
      if (reset) begin
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         drain_cnt_q <= drain_cnt_d;
         timeout_q   <= drain_to;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign drain_to    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign drain_exit = (state_q == S_DRAIN) && (!div_output_clk || drain_to);

   always_ff @(posedge reference_clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_OFF;
         settle_cnt_q <= '0;
         pend_valid_q <= 1'b0;
         pend_ratio_q <= '0;
         ratio_q      <= DEFAULT_RATIO;
         en_q         <= 1'b0;
         ready_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_ratio_q <= pend_ratio_d;
         ratio_q      <= ratio_d;
         en_q         <= en_d;
         ready_q      <= ready_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // A zero-ratio request is consumed but suppresses every other transition that cycle.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = '0;
      pend_valid_d = pend_valid_q;
      pend_ratio_d = pend_ratio_q;
      case (state_q)
         S_OFF: begin
            if (!accept && run) state_d = S_RESUME;
         end
         S_RUN: begin
            if (accept_legal) begin
               pend_valid_d = 1'b1;
               pend_ratio_d = req_ratio;
               state_d      = S_DRAIN;
            end else if (!accept && !run) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_exit) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = S_LOAD;
            else settle_cnt_d = settle_cnt_q + 4'd1;
         end
         S_LOAD: begin
            pend_valid_d = 1'b0;
            pend_ratio_d = '0;
            state_d      = run ? S_RESUME : S_OFF;
         end
         S_RESUME: state_d = S_RUN;
         default:  state_d = S_OFF;
      endcase
   end

   // Outputs are registered from the upcoming state so they align with it.
   always_comb begin
      en_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
      ready_d = (state_d == S_OFF) || (state_d == S_RUN);
      ratio_d = ratio_q;
      done_d  = 1'b0;
      err_d   = accept_zero;
      if (state_q == S_OFF && accept_legal) begin
         ratio_d = req_ratio;
         done_d  = 1'b1;
      end else if (state_q == S_LOAD && pend_valid_q) begin
         ratio_d = pend_ratio_q;
         done_d  = 1'b1;
      end
   end

   assign req_ready          = ready_q;
   assign clk_divider_enable = en_q;
   assign division_ratio     = ratio_q;
   assign done               = done_q;
   assign err_ratio          = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl; ratio loads are scoreboarded against done pulses.
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic       req_valid;
   logic [5:0] req_ratio;
   logic       req_ready;
   logic       div_output_clk;
   logic       clk_divider_enable;
   logic [5:0] division_ratio;
   logic       done;
   logic       err_ratio;
   logic       timeout_err;

   int n_assert = 0;
   int n_fail   = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   clk_div_ctrl #(
      .SETTLE_CYCLES(2),
      .DEFAULT_RATIO(6'd1),
      .DRAIN_TIMEOUT(4)
   ) dut (
      .reference_clk     (clk),
      .reset             (reset),
      .run               (run),
      .req_valid         (req_valid),
      .req_ratio         (req_ratio),
      .req_ready         (req_ready),
      .div_output_clk    (div_output_clk),
      .clk_divider_enable(clk_divider_enable),
      .division_ratio    (division_ratio),
      .done              (done),
      .err_ratio         (err_ratio),
      .timeout_err       (timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every done pulse must consume the oldest expected ratio.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         check("sb_has_entry", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("sb_done_ratio", 32'(division_ratio), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      reset = 1'b1; run = 1'b0; req_valid = 1'b0; req_ratio = '0; div_output_clk = 1'b1;
      #2;
      check("rst_ready", req_ready, 0);
      check("rst_en", clk_divider_enable, 0);
      check("rst_ratio", division_ratio, 1);
      check("rst_done", done, 0);
      check("rst_err", err_ratio, 0);
      check("rst_tmo", timeout_err, 0);
      tick(); tick();
      reset = 1'b0;
      tick();
      check("ready_after_rst", req_ready, 1);

      // OFF: load ratio 5, enable stays low
      req_valid = 1'b1; req_ratio = 6'd5; exp_q.push_back(6'd5);
      tick();
      req_valid = 1'b0;
      check("off_ratio5", division_ratio, 5);
      check("off_done", done, 1);
      check("off_en", clk_divider_enable, 0);
      tick();
      check("off_done_clr", done, 0);
      check("off_en2", clk_divider_enable, 0);
      check("off_ready", req_ready, 1);

      // OFF -> RESUME -> RUN
      run = 1'b1;
      tick();
      check("resume_en", clk_divider_enable, 0);
      check("resume_ready", req_ready, 0);
      tick();
      check("run_en", clk_divider_enable, 1);
      check("run_ready", req_ready, 1);

      // zero-ratio request in RUN
      req_valid = 1'b1; req_ratio = 6'd0;
      tick();
      req_valid = 1'b0;
      check("zero_err", err_ratio, 1);
      check("zero_ratio", division_ratio, 5);
      check("zero_en", clk_divider_enable, 1);
      check("zero_done", done, 0);
      tick();
      check("zero_err_clr", err_ratio, 0);
      check("zero_en2", clk_divider_enable, 1);
      check("zero_ready", req_ready, 1);

      // RUN retune to 3 with divider output already low
      div_output_clk = 1'b0;
      req_valid = 1'b1; req_ratio = 6'd3; exp_q.push_back(6'd3);
      tick();
      req_valid = 1'b0;
      check("drain_en", clk_divider_enable, 1);
      check("drain_ready", req_ready, 0);
      check("drain_ratio", division_ratio, 5);
      tick();
      check("settle1_en", clk_divider_enable, 0);
      check("settle1_ready", req_ready, 0);
      tick();
      check("settle2_en", clk_divider_enable, 0);
      tick();
      check("load_en", clk_divider_enable, 0);
      check("load_ratio_old", division_ratio, 5);
      check("load_done_low", done, 0);
      tick();
      check("resume_ratio3", division_ratio, 3);
      check("resume_done", done, 1);
      check("resume_en0", clk_divider_enable, 0);
      check("resume_ready0", req_ready, 0);
      tick();
      check("run3_en", clk_divider_enable, 1);
      check("run3_ready", req_ready, 1);
      check("run3_done", done, 0);

      // stop and retune to 8 in the same cycle
      run = 1'b0;
      req_valid = 1'b1; req_ratio = 6'd8; exp_q.push_back(6'd8);
      tick();
      req_valid = 1'b0;
      check("stop_drain_en", clk_divider_enable, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stop_settle_en", clk_divider_enable, 0);
         check("stop_no_done", done, 0);
      end
      tick();
      check("stop_ratio8", division_ratio, 8);
      check("stop_done", done, 1);
      check("stop_en", clk_divider_enable, 0);
      check("stop_ready_off", req_ready, 1);
      tick();
      check("stop_done_clr", done, 0);
      check("stop_en_off", clk_divider_enable, 0);

      // back to RUN, retune to 7 with divider output stuck high
      run = 1'b1;
      tick(); tick();
      check("run8_en", clk_divider_enable, 1);
      div_output_clk = 1'b1;
      req_valid = 1'b1; req_ratio = 6'd7; exp_q.push_back(6'd7);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("stuck_drain_en", clk_divider_enable, 1);
         check("stuck_drain_ready", req_ready, 0);
         check("stuck_no_tmo", timeout_err, 0);
         if (i < 3) tick();
      end
`ifdef CLK_DIV_CTRL_DRAIN_TIMEOUT_EN
      tick();
      check("tmo_pulse", timeout_err, 1);
      check("tmo_en", clk_divider_enable, 0);
`else
      tick();
      check("wait_en", clk_divider_enable, 1);
      check("wait_no_tmo", timeout_err, 0);
      div_output_clk = 1'b0;
      tick();
      check("wait_exit_en", clk_divider_enable, 0);
`endif
      tick();
      check("stuck_settle2_en", clk_divider_enable, 0);
      check("stuck_tmo_clr", timeout_err, 0);
      tick();
      tick();
      check("stuck_ratio7", division_ratio, 7);
      check("stuck_done", done, 1);
      tick();
      check("stuck_run_en", clk_divider_enable, 1);

      // reset while SETTLE holds a pending ratio of 9
      div_output_clk = 1'b0;
      req_valid = 1'b1; req_ratio = 6'd9;
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_rst_en", clk_divider_enable, 0);
      reset = 1'b1;
      #1;
      check("mid_rst_ratio", division_ratio, 1);
      check("mid_rst_en", clk_divider_enable, 0);
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_done", done, 0);
      run = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_ratio", division_ratio, 1);
         check("post_rst_done", done, 0);
      end
      check("post_rst_ready", req_ready, 1);

      // OFF with run and request together: load first, then resume
      run = 1'b1;
      req_valid = 1'b1; req_ratio = 6'd4; exp_q.push_back(6'd4);
      tick();
      req_valid = 1'b0;
      check("both_ratio4", division_ratio, 4);
      check("both_done", done, 1);
      check("both_en", clk_divider_enable, 0);
      check("both_ready", req_ready, 1);
      tick();
      check("both_resume_ready", req_ready, 0);
      check("both_resume_en", clk_divider_enable, 0);
      tick();
      check("both_run_en", clk_divider_enable, 1);

      tick();
      check("sb_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
